sevenseg_scan_ctrl: RTL and testbench



---
 rtl/sevenseg_scan_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed 8-digit seven-segment scan controller with double-buffered
// display registers, anti-ghosting blank window and 16-step PWM brightness.
module sevenseg_scan_ctrl #(
  parameter int SCAN_DIV     = 12500,
  parameter int BLANK_CYCLES = 64,
  parameter int NUM_DIGITS   = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_wr_en,
  input  logic [1:0]  i_wr_addr,
  input  logic [31:0] i_wr_data,
  input  logic        i_rd_en,
  input  logic [1:0]  i_rd_addr,
  output logic [31:0] o_rd_data,
  output logic [7:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic        o_frame_tick
);

  localparam int              CW         = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]   SLOT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]   BLANK_END  = CW'(BLANK_CYCLES);
  localparam logic [2:0]      DIGIT_LAST = 3'(NUM_DIGITS - 1);

  logic [CW-1:0] slot_cnt_q, slot_cnt_d;
  logic [2:0]    digit_idx_q, digit_idx_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  logic [31:0] sh_digits_q, sh_digits_d, act_digits_q, act_digits_d;
  logic [7:0]  sh_en_q, sh_en_d, act_en_q, act_en_d;
  logic [7:0]  sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [3:0]  sh_bright_q, sh_bright_d, act_bright_q, act_bright_d;
  logic        sh_gen_q, sh_gen_d, act_gen_q, act_gen_d;

  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        frame_tick_q, frame_tick_d;
  logic [31:0] rd_data_q, rd_data_d;

  logic        frame_tick_int;
  logic        lit;
  logic [3:0]  nibble;
  logic [6:0]  hex_pat;

  // CTRL write bits [30:20] are reserved and ignored.
  logic unused_wr_bits;
  assign unused_wr_bits = ^i_wr_data[30:20];

  assign frame_tick_int = (slot_cnt_q == '0) && (digit_idx_q == 3'd0);
  assign lit = act_gen_q && act_en_q[digit_idx_q] && (slot_cnt_q >= BLANK_END)
               && (slot_cnt_q[3:0] <= act_bright_q);
  assign nibble = act_digits_q[{digit_idx_q, 2'b00} +: 4];

  always_comb begin
    hex_pat = 7'h7E;
    case (nibble)
      4'h0: hex_pat = 7'h7E;
      4'h1: hex_pat = 7'h30;
      4'h2: hex_pat = 7'h6D;
      4'h3: hex_pat = 7'h79;
      4'h4: hex_pat = 7'h33;
      4'h5: hex_pat = 7'h5B;
      4'h6: hex_pat = 7'h5F;
      4'h7: hex_pat = 7'h70;
      4'h8: hex_pat = 7'h7F;
      4'h9: hex_pat = 7'h7B;
      4'hA: hex_pat = 7'h77;
      4'hB: hex_pat = 7'h1F;
      4'hC: hex_pat = 7'h4E;
      4'hD: hex_pat = 7'h3D;
      4'hE: hex_pat = 7'h4F;
      default: hex_pat = 7'h47;
    endcase
  end

  always_comb begin
    slot_cnt_d   = slot_cnt_q;
    digit_idx_d  = digit_idx_q;
    frame_cnt_d  = frame_cnt_q;
    sh_digits_d  = sh_digits_q;
    sh_en_d      = sh_en_q;
    sh_dp_d      = sh_dp_q;
    sh_bright_d  = sh_bright_q;
    sh_gen_d     = sh_gen_q;
    act_digits_d = act_digits_q;
    act_en_d     = act_en_q;
    act_dp_d     = act_dp_q;
    act_bright_d = act_bright_q;
    act_gen_d    = act_gen_q;
    rd_data_d    = rd_data_q;

    if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_d = '0;
      if (digit_idx_q == DIGIT_LAST) begin
        digit_idx_d = 3'd0;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
        digit_idx_d = digit_idx_q + 3'd1;
      end
    end else begin
      slot_cnt_d = slot_cnt_q + CW'(1);
    end

    // Active copies take the pre-write shadow, so a write on this cycle lands next frame.
    if (frame_tick_q) begin
      act_digits_d = sh_digits_q;
      act_en_d     = sh_en_q;
      act_dp_d     = sh_dp_q;
      act_bright_d = sh_bright_q;
      act_gen_d    = sh_gen_q;
    end

    if (i_wr_en) begin
      case (i_wr_addr)
        2'd0: sh_digits_d = i_wr_data;
        2'd1: begin
          sh_en_d     = i_wr_data[7:0];
          sh_dp_d     = i_wr_data[15:8];
          sh_bright_d = i_wr_data[19:16];
          sh_gen_d    = i_wr_data[31];
        end
        default: ;
      endcase
    end

    if (i_rd_en) begin
      case (i_rd_addr)
        2'd0:    rd_data_d = sh_digits_q;
        2'd1:    rd_data_d = {sh_gen_q, 11'd0, sh_bright_q, sh_dp_q, sh_en_q};
        2'd2:    rd_data_d = {frame_cnt_q, 13'd0, digit_idx_q};
        default: rd_data_d = 32'd0;
      endcase
    end

    frame_tick_d = frame_tick_int;
    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (lit) begin
      an_d  = ~(8'd1 << digit_idx_q);
      seg_d = ~hex_pat;
      dp_d  = ~act_dp_q[digit_idx_q];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_cnt_q   <= '0;
      digit_idx_q  <= 3'd0;
      frame_cnt_q  <= 16'd0;
      sh_digits_q  <= 32'd0;
      sh_en_q      <= 8'd0;
      sh_dp_q      <= 8'd0;
      sh_bright_q  <= 4'hF;
      sh_gen_q     <= 1'b0;
      act_digits_q <= 32'd0;
      act_en_q     <= 8'd0;
      act_dp_q     <= 8'd0;
      act_bright_q <= 4'hF;
      act_gen_q    <= 1'b0;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
      rd_data_q    <= 32'd0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      digit_idx_q  <= digit_idx_d;
      frame_cnt_q  <= frame_cnt_d;
      sh_digits_q  <= sh_digits_d;
      sh_en_q      <= sh_en_d;
      sh_dp_q      <= sh_dp_d;
      sh_bright_q  <= sh_bright_d;
      sh_gen_q     <= sh_gen_d;
      act_digits_q <= act_digits_d;
      act_en_q     <= act_en_d;
      act_dp_q     <= act_dp_d;
      act_bright_q <= act_bright_d;
      act_gen_q    <= act_gen_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign o_an         = an_q;
  assign o_seg        = seg_q;
  assign o_dp         = dp_q;
  assign o_frame_tick = frame_tick_q;
  assign o_rd_data    = rd_data_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: directed phases plus random register traffic,
// checked every cycle against a time-indexed model of the scan and register map.
module tb_sevenseg_scan_ctrl;

  localparam int SD = 32;
  localparam int BC = 4;
  localparam int ND = 8;
  localparam int FRAME = SD * ND;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = 2'd0;
  logic [31:0] wr_data = 32'd0;
  logic        rd_en = 1'b0;
  logic [1:0]  rd_addr = 2'd0;
  logic [31:0] rd_data;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  sevenseg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .NUM_DIGITS(ND)) dut (
    .clk(clk), .rstn(rstn),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
    .o_an(an), .o_seg(seg), .o_dp(dp), .o_frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Shadow (m_*) and active (a_*) views of the register file.
  logic [31:0] m_digits, a_digits;
  logic [7:0]  m_en, a_en, m_dp, a_dp;
  logic [3:0]  m_br, a_br;
  logic        m_gen, a_gen;
  logic [31:0] exp_rd;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic        exp_tick;
  int          s;
  int          n_assert = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_digits = 32'd0; a_digits = 32'd0;
    m_en = 8'd0; a_en = 8'd0; m_dp = 8'd0; a_dp = 8'd0;
    m_br = 4'hF; a_br = 4'hF; m_gen = 1'b0; a_gen = 1'b0;
    exp_rd = 32'd0;
    s = 0;
  endtask

  // s is the number of clock edges since reset released, i.e. the scan position.
  task automatic cyc();
    int slot, dig;
    logic lit;
    logic [3:0] nib;
    @(posedge clk);
    slot = s % SD;
    dig  = (s / SD) % ND;
    lit  = a_gen && a_en[dig] && (slot >= BC) && ((slot % 16) <= int'(a_br));
    nib  = a_digits[dig*4 +: 4];
    exp_an   = lit ? ~(8'd1 << dig) : 8'hFF;
    exp_seg  = lit ? ~hex_tab[nib] : 7'h7F;
    exp_dp   = lit ? ~a_dp[dig] : 1'b1;
    exp_tick = (s % FRAME) == 0;
    if (rd_en) begin
      case (rd_addr)
        2'd0:    exp_rd = m_digits;
        2'd1:    exp_rd = {m_gen, 11'd0, m_br, m_dp, m_en};
        2'd2:    exp_rd = {16'(s / FRAME), 13'd0, 3'(dig)};
        default: exp_rd = 32'd0;
      endcase
    end
    if (s >= 1 && ((s - 1) % FRAME) == 0) begin
      a_digits = m_digits; a_en = m_en; a_dp = m_dp; a_br = m_br; a_gen = m_gen;
    end
    if (wr_en) begin
      case (wr_addr)
        2'd0: m_digits = wr_data;
        2'd1: begin
          m_en = wr_data[7:0]; m_dp = wr_data[15:8]; m_br = wr_data[19:16]; m_gen = wr_data[31];
        end
        default: ;
      endcase
    end
    s++;
    #1;
    chk("an", {24'd0, an}, {24'd0, exp_an});
    chk("seg", {25'd0, seg}, {25'd0, exp_seg});
    chk("dp", {31'd0, dp}, {31'd0, exp_dp});
    chk("frame_tick", {31'd0, frame_tick}, {31'd0, exp_tick});
    chk("rd_data", rd_data, exp_rd);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    rd_en = 1'b1; rd_addr = a;
    cyc();
    rd_en = 1'b0;
  endtask

  task automatic wait_tick_visible();
    int budget;
    budget = 2 * FRAME;
    cyc();
    while (!exp_tick && budget > 0) begin
      cyc();
      budget--;
    end
    chk("tick_wait_budget", {31'd0, exp_tick}, 32'd1);
  endtask

  initial begin
    model_reset();
    #23;
    chk("reset_an", {24'd0, an}, 32'h000000FF);
    chk("reset_seg", {25'd0, seg}, 32'h0000007F);
    chk("reset_rd", rd_data, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Idle: everything dark, frame tick every 256 cycles starting at cycle 1.
    run(600);
    rd(2'd1);
    rd(2'd2);

    // Full brightness, all digits enabled.
    wr(2'd0, 32'h76543210);
    wr(2'd1, 32'h800F00FF);
    rd(2'd0);
    wr(2'd3, 32'hDEADBEEF);
    rd(2'd3);
    run(2 * FRAME + 40);

    // Minimum brightness: one lit cycle per slot.
    wr(2'd1, 32'h800000FF);
    run(FRAME + 20);

    // Write landing exactly on the frame-tick cycle shows up one frame later.
    wait_tick_visible();
    wr(2'd0, 32'hFEDCBA98);
    rd(2'd0);
    run(2 * FRAME);

    // Partial enable and decimal points.
    wr(2'd1, 32'h800F050F);
    run(2 * FRAME);

    // Random register traffic.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 40) == 0) begin
        wr_en = 1'b1;
        wr_addr = 2'($urandom_range(0, 3));
        wr_data = $urandom;
        if ($urandom_range(0, 1) == 1) wr_data[31] = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) begin
        rd_en = 1'b1;
        rd_addr = 2'($urandom_range(0, 3));
      end
      cyc();
      wr_en = 1'b0;
      rd_en = 1'b0;
    end

    // Asynchronous reset in the middle of digit 5's slot.
    wr(2'd1, 32'h800F00FF);
    begin
      int budget;
      budget = 3 * FRAME;
      while (!(((s / SD) % ND) == 5 && (s % SD) == 10) && budget > 0) begin
        cyc();
        budget--;
      end
      chk("digit5_budget", {31'd0, budget > 0}, 32'd1);
    end
    #2 rstn = 1'b0;
    #1;
    chk("async_an", {24'd0, an}, 32'h000000FF);
    chk("async_seg", {25'd0, seg}, 32'h0000007F);
    chk("async_dp", {31'd0, dp}, 32'd1);
    chk("async_tick", {31'd0, frame_tick}, 32'd0);
    chk("async_rd", rd_data, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    rstn = 1'b1;
    rd(2'd2);
    rd(2'd1);
    rd(2'd0);
    run(FRAME + 10);
    rd(2'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
